// File: rtl/counter_sequencer_if.sv
// Command and status bundle between system control and counter_sequencer.
// The master drives commands and configuration; the slave reports count and status.
interface counter_sequencer_if #(
    parameter int WIDTH      = 4,
    parameter int PRESCALE_W = 4
);
    logic                  start;
    logic                  stop;
    logic                  clear;
    logic                  dir_down;
    logic                  mode_reload;
    logic [WIDTH-1:0]      limit;
    logic [PRESCALE_W-1:0] prescale;
    logic [WIDTH-1:0]      count;
    logic                  tc;
    logic                  busy;
    logic                  done;

    modport master (
        output start, stop, clear, dir_down, mode_reload, limit, prescale,
        input  count, tc, busy, done
    );

    modport slave (
        input  start, stop, clear, dir_down, mode_reload, limit, prescale,
        output count, tc, busy, done
    );
endinterface

// File: rtl/counter_sequencer.sv
// Up/down counter sequencer with prescaled ticks, one-shot or auto-reload,
// start/stop/clear commands and registered tc/busy/done status.
module counter_sequencer #(
    parameter int WIDTH      = 4,
    parameter int PRESCALE_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    counter_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [WIDTH-1:0]      count_q, count_d;
    logic [PRESCALE_W-1:0] pre_q, pre_d;
    logic                  tc_q, tc_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  dir_q, dir_d;
    logic                  reload_q, reload_d;
    logic [WIDTH-1:0]      limit_q, limit_d;
    logic [PRESCALE_W-1:0] psc_q, psc_d;

    logic [WIDTH-1:0] start_val;
    logic [WIDTH-1:0] end_val;
    logic             go;

    assign start_val = dir_q ? limit_q : '0;
    assign end_val   = dir_q ? '0 : limit_q;
    // stop outranks start, so a combined start+stop never starts or resumes
    assign go        = bus.start && !bus.stop;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        pre_d    = pre_q;
        tc_d     = 1'b0;
        dir_d    = dir_q;
        reload_d = reload_q;
        limit_d  = limit_q;
        psc_d    = psc_q;

        if (bus.clear) begin
            state_d = S_IDLE;
            count_d = '0;
            pre_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (go) begin
                        dir_d    = bus.dir_down;
                        reload_d = bus.mode_reload;
                        limit_d  = bus.limit;
                        psc_d    = bus.prescale;
                        count_d  = bus.dir_down ? bus.limit : '0;
                        pre_d    = '0;
                        state_d  = S_RUN;
                    end
                end
                S_RUN: begin
                    if (bus.stop) begin
                        state_d = S_PAUSE;
                    end else if (pre_q == psc_q) begin
                        pre_d = '0;
                        if (count_q != end_val) begin
                            count_d = dir_q ? count_q - 1'b1
                                            : count_q + 1'b1;
                        end else begin
                            tc_d = 1'b1;
                            if (reload_q) begin
                                count_d = start_val;
                            end else begin
                                state_d = S_DONE;
                            end
                        end
                    end else begin
                        pre_d = pre_q + 1'b1;
                    end
                end
                S_PAUSE: begin
                    if (go) begin
                        state_d = S_RUN;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            pre_q    <= '0;
            tc_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dir_q    <= 1'b0;
            reload_q <= 1'b0;
            limit_q  <= '0;
            psc_q    <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            pre_q    <= pre_d;
            tc_q     <= tc_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dir_q    <= dir_d;
            reload_q <= reload_d;
            limit_q  <= limit_d;
            psc_q    <= psc_d;
        end
    end

    assign bus.count = count_q;
    assign bus.tc    = tc_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
endmodule

// File: tb/tb_counter_sequencer.sv
// Directed self-checking bench for counter_sequencer.
// Observed vector in every check is {count, tc, busy, done}.
module tb_counter_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    counter_sequencer_if #(.WIDTH(4), .PRESCALE_W(4)) bus ();

    counter_sequencer #(.WIDTH(4), .PRESCALE_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [6:0] obs;
    assign obs = {bus.count, bus.tc, bus.busy, bus.done};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cmds();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.clear = 1'b0;
    endtask

    task automatic cfg(input logic dn, input logic rl,
                       input logic [3:0] lim, input logic [3:0] psc);
        bus.dir_down    = dn;
        bus.mode_reload = rl;
        bus.limit       = lim;
        bus.prescale    = psc;
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
    endtask

    task automatic test_reset();
        idle_cmds();
        cfg(1'b0, 1'b0, 4'd0, 4'd0);
        rst = 1'b1;
        #12;
        total++;
        if (obs !== 7'b0000_000) begin
            bad++;
            $display("FAIL reset_hold got=%b exp=%b", obs, 7'b0000_000);
        end
        @(negedge clk);
        rst = 1'b0;
        step();
        total++;
        if (obs !== 7'b0000_000) begin
            bad++;
            $display("FAIL reset_idle got=%b exp=%b", obs, 7'b0000_000);
        end
    endtask

    task automatic test_up_oneshot();
        cfg(1'b0, 1'b0, 4'd5, 4'd0);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int e = 0; e <= 5; e++) begin
            if (e > 0) step();
            total++;
            if (obs !== {4'(e), 3'b010}) begin
                bad++;
                $display("FAIL up_os_e%0d got=%b exp=%b", e, obs, {4'(e), 3'b010});
            end
        end
        step();
        total++;
        if (obs !== {4'd5, 3'b101}) begin
            bad++;
            $display("FAIL up_os_term got=%b exp=%b", obs, {4'd5, 3'b101});
        end
        step();
        total++;
        if (obs !== {4'd5, 3'b001}) begin
            bad++;
            $display("FAIL up_os_after got=%b exp=%b", obs, {4'd5, 3'b001});
        end
        do_clear();
        total++;
        if (obs !== 7'b0000_000) begin
            bad++;
            $display("FAIL up_os_clear got=%b exp=%b", obs, 7'b0000_000);
        end
    endtask

    task automatic test_down_reload();
        logic [6:0] exp;
        int k;
        cfg(1'b1, 1'b1, 4'd3, 4'd2);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        total++;
        if (obs !== {4'd3, 3'b010}) begin
            bad++;
            $display("FAIL dn_rl_start got=%b exp=%b", obs, {4'd3, 3'b010});
        end
        exp = {4'd3, 3'b010};
        for (int e = 1; e <= 26; e++) begin
            step();
            exp[2] = 1'b0;
            if (e % 3 == 0) begin
                k = e / 3;
                if (k % 4 == 0) begin
                    exp = {4'd3, 3'b110};
                end else begin
                    exp = {4'(3 - (k % 4)), 3'b010};
                end
            end
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL dn_rl_e%0d got=%b exp=%b", e, obs, exp);
            end
        end
        do_clear();
    endtask

    task automatic test_pause();
        cfg(1'b0, 1'b0, 4'd9, 4'd3);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int e = 1; e <= 10; e++) step();
        total++;
        if (obs !== {4'd2, 3'b010}) begin
            bad++;
            $display("FAIL pause_pre got=%b exp=%b", obs, {4'd2, 3'b010});
        end
        cfg(1'b1, 1'b1, 4'd1, 4'd0);
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        for (int e = 0; e < 10; e++) begin
            if (e > 0) step();
            total++;
            if (obs !== {4'd2, 3'b000}) begin
                bad++;
                $display("FAIL pause_hold%0d got=%b exp=%b", e, obs, {4'd2, 3'b000});
            end
        end
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        step();
        bus.stop  = 1'b0;
        total++;
        if (obs !== {4'd2, 3'b000}) begin
            bad++;
            $display("FAIL pause_startstop got=%b exp=%b", obs, {4'd2, 3'b000});
        end
        step();
        bus.start = 1'b0;
        total++;
        if (obs !== {4'd2, 3'b010}) begin
            bad++;
            $display("FAIL resume_e0 got=%b exp=%b", obs, {4'd2, 3'b010});
        end
        step();
        total++;
        if (obs !== {4'd2, 3'b010}) begin
            bad++;
            $display("FAIL resume_e1 got=%b exp=%b", obs, {4'd2, 3'b010});
        end
        step();
        total++;
        if (obs !== {4'd3, 3'b010}) begin
            bad++;
            $display("FAIL resume_e2 got=%b exp=%b", obs, {4'd3, 3'b010});
        end
        do_clear();
    endtask

    task automatic test_priority();
        cfg(1'b0, 1'b0, 4'd9, 4'd0);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int e = 1; e <= 3; e++) step();
        bus.limit = 4'd2;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        total++;
        if (obs !== {4'd4, 3'b010}) begin
            bad++;
            $display("FAIL start_in_run got=%b exp=%b", obs, {4'd4, 3'b010});
        end
        for (int e = 5; e <= 9; e++) step();
        total++;
        if (obs !== {4'd9, 3'b010}) begin
            bad++;
            $display("FAIL limit_latched got=%b exp=%b", obs, {4'd9, 3'b010});
        end
        step();
        total++;
        if (obs !== {4'd9, 3'b101}) begin
            bad++;
            $display("FAIL limit_latched_end got=%b exp=%b", obs, {4'd9, 3'b101});
        end
        bus.limit = 4'd9;
        bus.start = 1'b1;
        step();
        step();
        step();
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
        bus.start = 1'b0;
        total++;
        if (obs !== 7'b0000_000) begin
            bad++;
            $display("FAIL clear_over_start got=%b exp=%b", obs, 7'b0000_000);
        end
    endtask

    task automatic test_limit0();
        cfg(1'b0, 1'b1, 4'd0, 4'd0);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            step();
            total++;
            if (obs !== {4'd0, 3'b110}) begin
                bad++;
                $display("FAIL lim0_rl_e%0d got=%b exp=%b", e, obs, {4'd0, 3'b110});
            end
        end
        do_clear();
        cfg(1'b0, 1'b0, 4'd0, 4'd0);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        total++;
        if (obs !== {4'd0, 3'b101}) begin
            bad++;
            $display("FAIL lim0_os_term got=%b exp=%b", obs, {4'd0, 3'b101});
        end
        step();
        total++;
        if (obs !== {4'd0, 3'b001}) begin
            bad++;
            $display("FAIL lim0_os_after got=%b exp=%b", obs, {4'd0, 3'b001});
        end
        do_clear();
    endtask

    task automatic test_all_ones();
        cfg(1'b0, 1'b1, 4'd15, 4'd0);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int e = 1; e <= 15; e++) step();
        total++;
        if (obs !== {4'd15, 3'b010}) begin
            bad++;
            $display("FAIL ones_top got=%b exp=%b", obs, {4'd15, 3'b010});
        end
        step();
        total++;
        if (obs !== {4'd0, 3'b110}) begin
            bad++;
            $display("FAIL ones_wrap got=%b exp=%b", obs, {4'd0, 3'b110});
        end
        do_clear();
    endtask

    task automatic test_reset_midrun();
        cfg(1'b0, 1'b0, 4'd9, 4'd1);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int e = 1; e <= 8; e++) step();
        total++;
        if (obs !== {4'd4, 3'b010}) begin
            bad++;
            $display("FAIL rst_pre got=%b exp=%b", obs, {4'd4, 3'b010});
        end
        #1;
        rst = 1'b1;
        #1;
        total++;
        if (obs !== 7'b0000_000) begin
            bad++;
            $display("FAIL rst_async got=%b exp=%b", obs, 7'b0000_000);
        end
        step();
        rst = 1'b0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        total++;
        if (obs !== {4'd0, 3'b010}) begin
            bad++;
            $display("FAIL rst_restart got=%b exp=%b", obs, {4'd0, 3'b010});
        end
        step();
        total++;
        if (obs !== {4'd0, 3'b010}) begin
            bad++;
            $display("FAIL rst_e1 got=%b exp=%b", obs, {4'd0, 3'b010});
        end
        step();
        total++;
        if (obs !== {4'd1, 3'b010}) begin
            bad++;
            $display("FAIL rst_e2 got=%b exp=%b", obs, {4'd1, 3'b010});
        end
        do_clear();
    endtask

    initial begin
        test_reset();
        test_up_oneshot();
        test_down_reload();
        test_pause();
        test_priority();
        test_limit0();
        test_all_ones();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
